ysyx_23060240_inst_encoder: RTL
===============================

# ysyx_23060240_inst_encoder

Instruction encoder for the NPC self-test and trap-stub path: the inverse of the immediate decoder. Accepts an operation kind, register fields and a 32-bit immediate on a valid/ready request port. Emits encoded RV32I instruction words on a valid/ready output port. Range-checks every immediate against its format. Expands the `LI` and `CALL` pseudo-ops into two-instruction sequences. Feeds the instruction buffer used for patching and boot stubs.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  request accepted this cycle when `req_valid` is also high.
- `req_op`  in  4  operation kind:
  - 0 LUI, 1 AUIPC, 2 JAL, 3 JALR, 4 BRANCH, 5 LOAD, 6 STORE, 7 OPIMM, 8 LI, 9 CALL.
  - 10–15 are illegal.
- `req_rd`, `req_rs1`, `req_rs2`  in  5 each  register fields.
- `req_funct3`  in  3  funct3 for JALR/BRANCH/LOAD/STORE/OPIMM.
- `req_imm`  in  32  immediate, two's complement.
- `out_valid`  out  1  encoded word present.
- `out_ready`  in  1  consumer takes the word.
- `out_inst`  out  32  encoded instruction.
- `out_last`  out  1  word is the final word of its request.
- `err`  out  1  one-cycle pulse: the accepted request was rejected.

## Operation
- FSM states:
  - IDLE: no word pending.
  - EMIT1: first or only word held.
  - EMIT2: second word of a pair held.
- `req_ready` = (state==IDLE) OR (`out_valid` & `out_ready` & `out_last`).
- Encoding, with opcodes per the RV32I spec:
  - LUI/AUIPC: `inst[31:12]`=`imm[31:12]`. `imm[11:0]` is ignored and never raises an error.
  - JAL (J-type): legal when imm is in [-2^20, 2^20-2] and `imm[0]`=0.
  - BRANCH (B-type): legal when imm is in [-4096, 4094] and `imm[0]`=0. Uses rs1, rs2 and funct3.
  - JALR/LOAD/OPIMM (I-type) and STORE (S-type): legal when imm is in [-2048, 2047]. The caller supplies shamt/funct7 bits in `imm[11:5]` for shifts.
- Pseudo-ops:
  - `lo` = `imm[11:0]`.
  - `hi` = (`imm[31:12]` + `imm[11]`) mod 2^20.
  - LI, when imm is in [-2048, 2047]: one word, `addi rd,x0,imm`.
  - LI, otherwise: `lui rd,hi`. If `lo`!=0, a second word `addi rd,rd,lo` follows; if `lo`==0 only the `lui` is emitted, with `out_last`=1.
  - CALL: always two words, `auipc rd,hi` then `jalr rd,lo(rd)` (funct3=000). `req_funct3` is ignored.
- Rejection (range violation or illegal op):
  - No word is emitted.
  - `err`=1 the cycle after acceptance.
  - State remains IDLE.
- All request fields are registered at acceptance. The second word of a pair is computed from the registered copy, so request inputs may change freely after the handshake.

## Timing
- Reset values: state IDLE, `out_valid`=0, `out_inst`=0, `out_last`=0, `err`=0. While `rst`=1, `req_ready`=0.
- Latency: request accepted at edge N → `out_valid`=1 with the first word after edge N (cycle N+1).
- Output hold: `out_inst` and `out_last` stay stable while `out_valid` & !`out_ready`.
- Second word: a handshake on a non-last word moves to EMIT2, and the second word is valid the next cycle. There is no bubble between the two words.
- Back-to-back: a last-word handshake and a new request acceptance in the same cycle load the new first word with no idle cycle. Sustained rate is one word per cycle.
- Rejected request during a last-word handshake: `out_valid` drops to 0 next cycle and `err`=1.
- Reset mid-operation: `rst` in EMIT1/EMIT2 discards the pending word(s). The next cycle shows the reset values, and the remaining word is never emitted.
- `err` is never asserted in the same cycle as `out_valid` for the same request.

## Test plan
- LI x5, 0x12345FFF → two words: 0x123462B7 (`out_last`=0), then 0xFFF28293 (`out_last`=1) on consecutive cycles with `out_ready`=1.
- LI x1, -5 → single word 0xFFB00093, `out_last`=1. LI x1, 0x00010000 → single `lui` 0x000100B7, `out_last`=1.
- BRANCH beq (funct3 0), rs1=1, rs2=2, imm=8 → 0x00208463. JAL rd=1, imm=-4 → 0xFFDFF0EF.
- Rejections → `err` pulse one cycle, `out_valid` stays 0:
  - JAL imm=3;
  - JAL imm=0x100000;
  - OPIMM imm=2048;
  - `req_op`=12.
- Backpressure: LI x5, 0x12345FFF with `out_ready`=0 for 3 cycles → 0x123462B7 held stable and `req_ready`=0. Then release: second word, and a queued LI x1,-5 is accepted on the last handshake → 0xFFB00093 the next cycle.
- Reset during EMIT2 of CALL rd=1, imm=0x1800 → `out_valid`=0 after the reset edge, no `jalr` word, `req_ready`=1 after `rst` drops.

Source files
------------

// File: rtl/ysyx_23060240_inst_encoder.sv
`default_nettype none
// ============================================================================
// Module   : ysyx_23060240_inst_encoder
// Purpose  : Encodes RV32I instruction words from an operation kind, register
//            fields and a 32-bit immediate. Range-checks immediates and
//            expands the LI / CALL pseudo-ops into two-word sequences.
// Revision : 1.0  initial release
// ============================================================================
module ysyx_23060240_inst_encoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [4:0]  req_rd,
  input  logic [4:0]  req_rs1,
  input  logic [4:0]  req_rs2,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic        out_last,
  output logic        err
);

  // Operation kinds on req_op
  localparam logic [3:0] OP_LUI    = 4'd0;
  localparam logic [3:0] OP_AUIPC  = 4'd1;
  localparam logic [3:0] OP_JAL    = 4'd2;
  localparam logic [3:0] OP_JALR   = 4'd3;
  localparam logic [3:0] OP_BRANCH = 4'd4;
  localparam logic [3:0] OP_LOAD   = 4'd5;
  localparam logic [3:0] OP_STORE  = 4'd6;
  localparam logic [3:0] OP_OPIMM  = 4'd7;
  localparam logic [3:0] OP_LI     = 4'd8;
  localparam logic [3:0] OP_CALL   = 4'd9;

  // RV32I major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  // Output FSM
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMIT1 = 2'd1;
  localparam logic [1:0] ST_EMIT2 = 2'd2;

  logic [1:0]  state;
  logic [3:0]  op_q;
  logic [4:0]  rd_q;
  logic [11:0] lo_q;

  logic        fits_i;
  logic        fits_b;
  logic        fits_j;
  logic [19:0] hi;
  logic [11:0] lo;
  logic        legal;
  logic        pair;
  logic [31:0] first_word;
  logic [31:0] second_word;
  logic        accept;
  logic        last_done;

  // A value fits in N signed bits when every bit from N-1 upward equals the sign.
  assign fits_i = (req_imm[31:11] == {21{req_imm[31]}});
  assign fits_b = (req_imm[31:12] == {20{req_imm[31]}});
  assign fits_j = (req_imm[31:20] == {12{req_imm[31]}});

  // Upper part is rounded up when the low part will be sign-extended negative.
  assign lo = req_imm[11:0];
  assign hi = req_imm[31:12] + {19'd0, req_imm[11]};

  assign out_valid = (state != ST_IDLE);
  assign last_done = out_valid & out_ready & out_last;
  assign req_ready = ~rst & ((state == ST_IDLE) | last_done);
  assign accept    = req_valid & req_ready;

  // Encode the first (or only) word and judge legality of the live request
  always_comb begin
    legal      = 1'b1;
    pair       = 1'b0;
    first_word = 32'd0;
    case (req_op)
      OP_LUI:    first_word = {req_imm[31:12], req_rd, OPC_LUI};
      OP_AUIPC:  first_word = {req_imm[31:12], req_rd, OPC_AUIPC};
      OP_JAL: begin
        legal      = fits_j & ~req_imm[0];
        first_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12],
                      req_rd, OPC_JAL};
      end
      OP_JALR: begin
        legal      = fits_i;
        first_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_JALR};
      end
      OP_BRANCH: begin
        legal      = fits_b & ~req_imm[0];
        first_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                      req_imm[4:1], req_imm[11], OPC_BRANCH};
      end
      OP_LOAD: begin
        legal      = fits_i;
        first_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD};
      end
      OP_STORE: begin
        legal      = fits_i;
        first_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0],
                      OPC_STORE};
      end
      OP_OPIMM: begin
        legal      = fits_i;
        first_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OPIMM};
      end
      OP_LI: begin
        if (fits_i) begin
          first_word = {lo, 5'd0, 3'b000, req_rd, OPC_OPIMM};
        end else begin
          first_word = {hi, req_rd, OPC_LUI};
          pair       = (lo != 12'd0);
        end
      end
      OP_CALL: begin
        first_word = {hi, req_rd, OPC_AUIPC};
        pair       = 1'b1;
      end
      default:   legal = 1'b0;
    endcase
  end

  // Second word of a pair comes only from the registered request copy
  always_comb begin
    if (op_q == OP_CALL) begin
      second_word = {lo_q, rd_q, 3'b000, rd_q, OPC_JALR};
    end else begin
      second_word = {lo_q, rd_q, 3'b000, rd_q, OPC_OPIMM};
    end
  end

  // Output FSM: load on acceptance, advance on output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      out_inst <= 32'd0;
      out_last <= 1'b0;
      err      <= 1'b0;
      op_q     <= 4'd0;
      rd_q     <= 5'd0;
      lo_q     <= 12'd0;
    end else begin
      err <= 1'b0;
      if (accept) begin
        op_q <= req_op;
        rd_q <= req_rd;
        lo_q <= lo;
        if (legal) begin
          state    <= ST_EMIT1;
          out_inst <= first_word;
          out_last <= ~pair;
        end else begin
          state <= ST_IDLE;
          err   <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        if (out_last) begin
          state <= ST_IDLE;
        end else begin
          state    <= ST_EMIT2;
          out_inst <= second_word;
          out_last <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
